// File: rtl/softmax_seq_if.sv
// softmax_seq_if: valid/ready stream bundle for softmax_seq.
//   in_valid/in_ready/in_data        : logit input stream (signed logits)
//   out_valid/out_ready/out_data     : probability output stream (unsigned Q0.PROB_WIDTH)
//   out_index/out_last               : class index of out_data, high on the final class
// Modports:
//   slave  : the softmax block (consumes logits, produces probabilities)
//   master : the environment driving logits and consuming probabilities
interface softmax_seq_if #(
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned PROB_WIDTH = 8,
    parameter int unsigned IDX_W      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [PROB_WIDTH-1:0]       out_data;
    logic [IDX_W-1:0]            out_index;
    logic                        out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_index,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/softmax_seq.sv
// softmax_seq: sequential base-2 softmax over N_CLASSES signed logits.
//   p_i = 2^x_i / sum_j 2^x_j, evaluated with the frame maximum subtracted so the
//   exponential of the largest logit is exactly 2^FRAC_BITS. One shared restoring
//   divider produces one quotient bit per cycle.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus_io       : softmax_seq_if.slave (logit input stream, probability output stream)
//   argmax       : index of the largest logit of the current frame (lowest index on ties)
//   argmax_valid : argmax is final; from end of accumulation until the last output is taken
//   busy         : high whenever the block is not loading logits
module softmax_seq #(
    parameter int unsigned N_CLASSES  = 10,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned PROB_WIDTH = 8,
    localparam int unsigned IDX_W     = $clog2(N_CLASSES)
) (
    input  logic             clk,
    input  logic             rst_n,
    softmax_seq_if.slave     bus_io,
    output logic [IDX_W-1:0] argmax,
    output logic             argmax_valid,
    output logic             busy
);

    localparam int unsigned EXP_W = FRAC_BITS + 1;
    localparam int unsigned SUM_W = EXP_W + $clog2(N_CLASSES);
    localparam int unsigned REM_W = SUM_W + 1;
    localparam int unsigned QUO_W = PROB_WIDTH + 1;
    localparam int unsigned BIT_W = $clog2(PROB_WIDTH + 1);
    localparam int unsigned DW    = IN_WIDTH + 1;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_CLASSES - 1);
    localparam logic [BIT_W-1:0] TopBit  = BIT_W'(PROB_WIDTH);
    localparam logic [DW-1:0]    FracLim = DW'(FRAC_BITS);
    localparam logic [EXP_W-1:0] ExpOne  = EXP_W'(1) << FRAC_BITS;

    typedef enum logic [1:0] {StLoad, StAccum, StDiv, StOut} state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            cls_q, cls_d;
    logic signed [IN_WIDTH-1:0]  buf_q [N_CLASSES];
    logic signed [IN_WIDTH-1:0]  max_q, max_d;
    logic [IDX_W-1:0]            argmax_q, argmax_d;
    logic                        argmax_valid_q, argmax_valid_d;
    logic [SUM_W-1:0]            sum_q, sum_d;
    logic [REM_W-1:0]            rem_q, rem_d;
    logic [PROB_WIDTH-1:0]       quo_q, quo_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic                        out_valid_q, out_valid_d;
    logic [PROB_WIDTH-1:0]       out_data_q, out_data_d;
    logic [IDX_W-1:0]            out_index_q, out_index_d;
    logic                        out_last_q, out_last_d;

    // Exponential term of the class addressed by cls_q, shared by ACCUM and DIV.
    logic signed [IN_WIDTH-1:0]  cur_x;
    logic [DW-1:0]               neg;
    logic [EXP_W-1:0]            e_val;

    assign cur_x = buf_q[cls_q];
    // max - x on sign-extended operands; the true difference is in [0, 2^DW-1],
    // so the unsigned result is exact even for a -2^(IN_WIDTH-1) logit.
    assign neg   = {max_q[IN_WIDTH-1], max_q} - {cur_x[IN_WIDTH-1], cur_x};
    assign e_val = (neg > FracLim) ? '0 : (ExpOne >> neg);

    // Restoring divider step. The remainder starts at E_i (<= sum), so the first
    // step yields the 2^PROB_WIDTH quotient bit and no higher bits exist.
    logic [REM_W-1:0]            rem_cur;
    logic                        ge;
    logic [REM_W-1:0]            rem_sub;
    logic [REM_W-1:0]            rem_shift;
    logic [QUO_W-1:0]            quo_next;

    assign rem_cur   = (bit_q == TopBit) ? REM_W'(e_val) : rem_q;
    assign ge        = rem_cur >= REM_W'(sum_q);
    assign rem_sub   = ge ? (rem_cur - REM_W'(sum_q)) : rem_cur;
    // rem_sub < sum < 2^SUM_W, so the shift never loses a set bit.
    assign rem_shift = rem_sub << 1;
    assign quo_next  = {quo_q, ge};

    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        max_d          = max_q;
        argmax_d       = argmax_q;
        argmax_valid_d = argmax_valid_q;
        sum_d          = sum_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        bit_d          = bit_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_index_d    = out_index_q;
        out_last_d     = out_last_q;

        unique case (state_q)
            StLoad: begin
                if (bus_io.in_valid) begin
                    // Strictly greater keeps the lowest index on ties.
                    if (cls_q == '0 || $signed(bus_io.in_data) > max_q) begin
                        max_d    = bus_io.in_data;
                        argmax_d = cls_q;
                    end
                    if (cls_q == LastIdx) begin
                        state_d = StAccum;
                        cls_d   = '0;
                        sum_d   = '0;
                    end else begin
                        cls_d = cls_q + 1'b1;
                    end
                end
            end
            StAccum: begin
                sum_d = sum_q + SUM_W'(e_val);
                if (cls_q == LastIdx) begin
                    state_d        = StDiv;
                    cls_d          = '0;
                    bit_d          = TopBit;
                    argmax_valid_d = 1'b1;
                end else begin
                    cls_d = cls_q + 1'b1;
                end
            end
            StDiv: begin
                rem_d = rem_shift;
                quo_d = quo_next[PROB_WIDTH-1:0];
                if (bit_q == '0) begin
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    // Quotient of exactly 1.0 only occurs when every other E is 0.
                    out_data_d  = quo_next[PROB_WIDTH] ? '1 : quo_next[PROB_WIDTH-1:0];
                    out_index_d = cls_q;
                    out_last_d  = (cls_q == LastIdx);
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            StOut: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d        = StLoad;
                        argmax_valid_d = 1'b0;
                        cls_d          = '0;
                    end else begin
                        state_d = StDiv;
                        cls_d   = cls_q + 1'b1;
                        bit_d   = TopBit;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StLoad;
            cls_q          <= '0;
            max_q          <= '0;
            argmax_q       <= '0;
            argmax_valid_q <= 1'b0;
            sum_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            bit_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_index_q    <= '0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cls_q          <= cls_d;
            max_q          <= max_d;
            argmax_q       <= argmax_d;
            argmax_valid_q <= argmax_valid_d;
            sum_q          <= sum_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            bit_q          <= bit_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_index_q    <= out_index_d;
            out_last_q     <= out_last_d;
        end
    end

    // Logit storage needs no reset; it is fully rewritten before being read.
    always_ff @(posedge clk) begin
        if (state_q == StLoad && bus_io.in_valid) begin
            buf_q[cls_q] <= bus_io.in_data;
        end
    end

    assign bus_io.in_ready  = (state_q == StLoad);
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_index = out_index_q;
    assign bus_io.out_last  = out_last_q;
    assign argmax           = argmax_q;
    assign argmax_valid     = argmax_valid_q;
    assign busy             = (state_q != StLoad);

endmodule

// File: tb/tb_softmax_seq.sv
// tb_softmax_seq: directed self-checking bench for softmax_seq (10 classes, 8-bit logits,
// 8 fraction bits, 8-bit probabilities). A frame-level model computes the expected
// probabilities and argmax; a negedge compare process checks every accepted output.
module tb_softmax_seq;

    typedef int frame_t [10];
    typedef struct {
        int idx;
        int data;
        int last;
        int amax;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] argmax;
    logic       argmax_valid;
    logic       busy;

    softmax_seq_if #(.IN_WIDTH(8), .PROB_WIDTH(8), .IDX_W(4)) bus ();

    softmax_seq #(
        .N_CLASSES (10),
        .IN_WIDTH  (8),
        .FRAC_BITS (8),
        .PROB_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_io      (bus),
        .argmax      (argmax),
        .argmax_valid(argmax_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int rise_cyc [10];
    int cap [10];
    int cap_amax = -1;
    exp_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Frame-level model: base-2 softmax relative to the maximum, truncating.
    function automatic int frame_argmax(input frame_t f);
        int am = 0;
        for (int i = 1; i < 10; i++) if (f[i] > f[am]) am = i;
        return am;
    endfunction

    function automatic int model_e(input frame_t f, input int i);
        int d;
        d = f[frame_argmax(f)] - f[i];
        return (d > 8) ? 0 : (1 << (8 - d));
    endfunction

    function automatic int model_sum(input frame_t f);
        int s = 0;
        for (int i = 0; i < 10; i++) s += model_e(f, i);
        return s;
    endfunction

    function automatic void push_model(input frame_t f);
        exp_t e;
        int   q;
        for (int i = 0; i < 10; i++) begin
            q = model_e(f, i) * 256 / model_sum(f);
            if (q > 255) q = 255;
            e.idx  = i;
            e.data = q;
            e.last = (i == 9) ? 1 : 0;
            e.amax = frame_argmax(f);
            exp_q.push_back(e);
        end
    endfunction

    // Compare process: checks outputs at the negedge before each accepting posedge.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [3:0] prev_index = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            if (!prev_valid && bus.out_index < 10) rise_cyc[bus.out_index] = cyc;
            chk("in_ready_low_while_out", int'(bus.in_ready), 0);
            chk("busy_while_out", int'(busy), 1);
            if (prev_valid && !prev_ready) begin
                chk("stall_data_stable", int'(bus.out_data), int'(prev_data));
                chk("stall_index_stable", int'(bus.out_index), int'(prev_index));
            end
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_index", int'(bus.out_index), e.idx);
                    chk("out_data", int'(bus.out_data), e.data);
                    chk("out_last", int'(bus.out_last), e.last);
                    chk("argmax_valid", int'(argmax_valid), 1);
                    chk("argmax", int'(argmax), e.amax);
                    if (bus.out_index < 10) cap[bus.out_index] = int'(bus.out_data);
                    cap_amax = int'(argmax);
                end
            end
        end
        prev_valid = rst_n && bus.out_valid;
        prev_ready = bus.out_ready;
        prev_data  = bus.out_data;
        prev_index = bus.out_index;
    end

    // All tasks start and end at posedge + #1.
    task automatic send_frame(input frame_t f, input bit gaps);
        int t;
        push_model(f);
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(f[i]);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.in_ready && t < 300);
            if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
            if (i == 9) acc_cyc = cyc + 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("frame_done", exp_q.size(), 0);
    endtask

    task automatic wait_out_state(input int idx, input bit valid);
        int t = 0;
        while (!(int'(bus.out_index) == idx && bus.out_valid == valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("wait_out_state", int'(bus.out_index) * 2 + int'(bus.out_valid),
            idx * 2 + int'(valid));
    endtask

    frame_t uni, peak, sat, negall, ties;

    initial begin
        for (int i = 0; i < 10; i++) begin
            uni[i]    = 0;
            peak[i]   = 0;
            sat[i]    = 0;
            negall[i] = -128;
            ties[i]   = 0;
        end
        peak[3] = 5;
        sat[7]  = 20;
        ties[2] = 4;
        ties[6] = 4;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_index", int'(bus.out_index), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_argmax", int'(argmax), 0);
        chk("rst_argmax_valid", int'(argmax_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Pin the model against hand-computed values.
        chk("model_sum_uniform", model_sum(uni), 2560);
        chk("model_sum_peaked", model_sum(peak), 328);
        chk("model_sum_sat", model_sum(sat), 256);
        chk("model_e_sat_other", model_e(sat, 0), 0);
        chk("model_argmax_ties", frame_argmax(ties), 2);

        // Uniform, with latency and output spacing.
        send_frame(uni, 1'b0);
        @(posedge clk);
        #1;
        chk("busy_after_load", int'(busy), 1);
        chk("in_ready_after_load", int'(bus.in_ready), 0);
        wait_done();
        for (int i = 0; i < 10; i++) chk("uniform_p", cap[i], 25);
        chk("uniform_argmax", cap_amax, 0);
        chk("latency_first_out", rise_cyc[0] - acc_cyc, 19);
        chk("spacing_next_out", rise_cyc[1] - rise_cyc[0], 10);
        chk("argmax_valid_cleared", int'(argmax_valid), 0);
        chk("in_ready_after_frame", int'(bus.in_ready), 1);

        // Peaked with input gaps and a 5-cycle output stall at class 4.
        send_frame(peak, 1'b1);
        wait_out_state(3, 1'b0);
        bus.out_ready = 1'b0;
        wait_out_state(4, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("stall_held_index", int'(bus.out_index), 4);
        chk("stall_held_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        wait_done();
        chk("peaked_p3", cap[3], 199);
        chk("peaked_p0", cap[0], 6);
        chk("peaked_p9", cap[9], 6);
        chk("peaked_argmax", cap_amax, 3);

        // Saturation / underflow.
        send_frame(sat, 1'b0);
        wait_done();
        chk("sat_p7", cap[7], 255);
        chk("sat_p0", cap[0], 0);
        chk("sat_argmax", cap_amax, 7);
        chk("sat_latency", rise_cyc[0] - acc_cyc, 19);

        // Shift invariance: all -128 behaves like uniform.
        send_frame(negall, 1'b1);
        wait_done();
        for (int i = 0; i < 10; i++) chk("neg_uniform_p", cap[i], 25);
        chk("neg_argmax", cap_amax, 0);

        // Ties: lowest index wins.
        send_frame(ties, 1'b0);
        wait_done();
        chk("ties_argmax", cap_amax, 2);

        // Reset during DIV of class 5.
        send_frame(peak, 1'b0);
        wait_out_state(4, 1'b0);
        @(posedge clk);
        #1;
        chk("busy_in_div", int'(busy), 1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_argmax_valid", int'(argmax_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_busy", int'(busy), 0);

        send_frame(uni, 1'b0);
        wait_done();
        for (int i = 0; i < 10; i++) chk("post_rst_uniform_p", cap[i], 25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/softmax_seq.md
Name: softmax_seq

Overview:
- Parametrised, sequential successor to the combinational 10-class softmax used at the classifier output of the CNN.
- Accepts N_CLASSES signed integer logits over a valid/ready stream and computes base-2 softmax, p_i = 2^x_i / sum_j 2^x_j.
- Subtracts the maximum logit for range safety, so no overflow for any input values.
- Emits one fixed-point probability per class over a valid/ready stream, plus the argmax.
- Uses one shared iterative divider instead of N parallel dividers.

Parameters:
- N_CLASSES, 10, number of logits per frame (>=2).
- IN_WIDTH, 8, logit width, signed two's complement integer.
- FRAC_BITS, 8, fraction bits of the exponential term; exp of the max logit = 2^FRAC_BITS.
- PROB_WIDTH, 8, output probability width, unsigned Q0.PROB_WIDTH.
- Derived, not overridable:
  - IDX_W = clog2(N_CLASSES)
  - EXP_W = FRAC_BITS+1
  - SUM_W = EXP_W+clog2(N_CLASSES)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  logit valid
- in_ready  out  1  block can accept a logit
- in_data  in  IN_WIDTH  signed logit; class index = order of acceptance within the frame
- out_valid  out  1  probability valid
- out_ready  in  1  consumer accepts probability
- out_data  out  PROB_WIDTH  probability of class out_index
- out_index  out  IDX_W  class index of out_data
- out_last  out  1  high with out_valid for class N_CLASSES-1
- argmax  out  IDX_W  index of the largest logit of the current frame
- argmax_valid  out  1  argmax is valid; high from end of ACCUM until the frame's last output is accepted
- busy  out  1  high in any state other than LOAD

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD, in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, argmax=0, argmax_valid=0, busy=0.
  - Load counter cleared; logit buffer contents don't-care.
  - Reset takes effect from any state, including mid-divide or mid-output; the partial frame is discarded.
- LOAD:
  - Each cycle with in_valid&&in_ready stores in_data at buf[cnt] and updates running max/argmax.
  - Strictly-greater comparison, so on ties the lowest index wins.
  - When the N_CLASSES-th logit is accepted: go to ACCUM, in_ready=0 from the next cycle.
  - in_ready is 1 only in LOAD; no input is accepted during ACCUM/DIV/OUT.
- ACCUM: N_CLASSES cycles, one class per cycle.
  - d = buf[i] - max, computed at IN_WIDTH+1 bits, always <= 0.
  - E_i = 0 if d < -FRAC_BITS, else 1 << (FRAC_BITS+d).
  - sum += E_i.
  - sum ranges over [2^FRAC_BITS, N_CLASSES*2^FRAC_BITS] and never overflows SUM_W.
  - E_i is recomputed from buf in DIV; it is not stored.
  - On exit, argmax_valid=1.
- DIV: restoring divider, one quotient bit per cycle, PROB_WIDTH+1 cycles per class.
  - q = floor(E_i * 2^PROB_WIDTH / sum).
  - Saturate: if q == 2^PROB_WIDTH (only when all other E are 0), out_data = 2^PROB_WIDTH-1.
  - Then go to OUT.
- OUT:
  - out_valid=1 with out_data/out_index/out_last registered and held stable until out_ready.
  - On out_valid&&out_ready:
    - If i < N_CLASSES-1: i++ and return to DIV; out_valid=0 next cycle.
    - Else: go to LOAD, argmax_valid=0, in_ready=1 next cycle.
  - If out_ready is already high when out_valid rises, acceptance takes 1 cycle.
- Latency, with out_ready tied 1: last input accepted -> first out_valid = N_CLASSES + PROB_WIDTH + 1 cycles.
  - Each subsequent output follows PROB_WIDTH+2 cycles after the previous one.
- Arithmetic:
  - All probability values are unsigned and truncating; sum of outputs <= 2^PROB_WIDTH.
  - Negative logits are handled solely through max subtraction.
  - The most negative input (-2^(IN_WIDTH-1)) with a positive max must not overflow d.
- A frame is atomic: once LOAD completes, no new frame starts until out_last is accepted.

Test Plan (N_CLASSES=10, IN_WIDTH=8, FRAC_BITS=8, PROB_WIDTH=8):
- Uniform:
  - Stimulus: all ten logits = 0.
  - Required: E=256 each, sum=2560, every out_data=25, argmax=0, out_last only on index 9, out_index sequence 0..9.
- Peaked:
  - Stimulus: x3=5, all others 0.
  - Required: sum=256+9*8=328, out_data[3]=199, all others 6, argmax=3.
- Saturation/underflow:
  - Stimulus: x7=20, all others 0.
  - Required: others clamp to E=0, sum=256, out_data[7]=255 (saturated), all others 0, argmax=7.
- Shift invariance and ties:
  - Stimulus: all logits = -128.
  - Required: identical to the Uniform case (all 25, argmax=0).
  - Stimulus: x2=x6=4, all others 0.
  - Required: argmax=2.
- Handshakes:
  - Stimulus: drop in_valid randomly during LOAD; hold out_ready=0 for 5 cycles at class 4.
  - Required: out_data/out_index stay stable while stalled; in_ready=0 and busy=1 throughout processing; results match the Peaked case.
  - Required: first out_valid occurs exactly 19 cycles after the last input is accepted (out_ready=1).
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for 1 cycle during DIV of class 5.
  - Required: next cycle out_valid=0, argmax_valid=0, in_ready=1, busy=0.
  - Required: a following Uniform frame produces all 25.
